// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a sync_fifo_param instance and the logic around it.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface sync_fifo_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             write;
   logic [WIDTH-1:0] din;
   logic             read;
   logic             err_clr;
   logic [WIDTH-1:0] dout;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CW-1:0]    cnt;
   logic             overflow;
   logic             underflow;

   modport master (
      output write, din, read, err_clr,
      input  dout, full, empty, almost_full, almost_empty, cnt, overflow, underflow
   );

   modport slave (
      input  write, din, read, err_clr,
      output dout, full, empty, almost_full, almost_empty, cnt, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock show-ahead FIFO with a registered occupancy count and threshold flags.
// Define SYNC_FIFO_STICKY_ERR_EN to build the sticky overflow/underflow flags cleared by err_clr.
module sync_fifo_param #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   sync_fifo_param_if.slave     bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LVL   = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AE_LVL   = CW'(AEMPTY_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [CW-1:0]    cnt_q, cnt_nxt;
   logic             full_q, empty_q, afull_q, aempty_q;
   logic             wr_acc, rd_acc;

   // A full FIFO still takes a write when the head is read in the same cycle.
   assign rd_acc = bus.read && !empty_q;
   assign wr_acc = bus.write && (!full_q || bus.read);

   always_comb begin
      cnt_nxt = cnt_q;
      case ({wr_acc, rd_acc})
         2'b10:   cnt_nxt = cnt_q + 1'b1;
         2'b01:   cnt_nxt = cnt_q - 1'b1;
         default: cnt_nxt = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (rd_acc) rptr <= rptr + 1'b1;
         cnt_q    <= cnt_nxt;
         full_q   <= (cnt_nxt == CNT_FULL);
         empty_q  <= (cnt_nxt == '0);
         afull_q  <= (cnt_nxt >= AF_LVL);
         aempty_q <= (cnt_nxt <= AE_LVL);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc) mem[wptr] <= bus.din;
   end

   assign bus.dout         = mem[rptr];
   assign bus.cnt          = cnt_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;

`ifdef SYNC_FIFO_STICKY_ERR_EN
   logic ovf_q, unf_q;

   // A new rejection in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= (bus.write && !wr_acc) || (ovf_q && !bus.err_clr);
         unf_q <= (bus.read && !rd_acc) || (unf_q && !bus.err_clr);
      end
   end

   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.overflow   = 1'b0;
   assign bus.underflow  = 1'b0;
`endif
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock synchronous FIFO; next generation of the team's fixed 8x16 FIFO.
- Adds generic width/depth, a registered occupancy count, programmable almost-full/almost-empty flags, full-pass-through on simultaneous read/write, and optional sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain; drop-in for the 8x16 FIFO at default parameters (except the reset polarity).

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AFULL_THRESH, DEPTH-2, almost_full asserted when cnt >= AFULL_THRESH (1..DEPTH)
AEMPTY_THRESH, 2, almost_empty asserted when cnt <= AEMPTY_THRESH (0..DEPTH-1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
write  input  1  write request
din  input  WIDTH  write data
read  input  1  read request
dout  output  WIDTH  show-ahead data at head of FIFO
full  output  1  cnt == DEPTH
empty  output  1  cnt == 0
almost_full  output  1  cnt >= AFULL_THRESH
almost_empty  output  1  cnt <= AEMPTY_THRESH
cnt  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write rejected (optional feature)
underflow  output  1  sticky: read rejected (optional feature)
err_clr  input  1  clears overflow/underflow (optional feature)

Behaviour:
- Interface is fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - wptr=0, rptr=0, cnt=0.
  - empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
  - Memory is not reset.
  - rst overrides write/read in the same cycle; a mid-operation reset discards all contents.
- Acceptance, evaluated on current-cycle state:
  - rd_acc = read && !empty
  - wr_acc = write && (!full || read)
- Cases on {wr_acc, rd_acc}:
  - 10: mem[wptr]<=din, wptr+1, cnt+1
  - 01: rptr+1, cnt-1
  - 11: write and read both happen, cnt unchanged. This includes full with read+write (pass-through; cnt stays DEPTH).
  - 00: no change
- Empty with read+write: write accepted, read rejected; cnt becomes 1.
- Full with write only: write rejected; wptr, cnt and full stay stable.
- Empty with read only: rptr, cnt and empty stay stable.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH. cnt is one bit wider and never exceeds DEPTH or goes below 0.
- Flag timing:
  - All flags are registers, computed from next-cnt, so they always agree with cnt in the same cycle.
  - Example: a write at cnt=DEPTH-1 gives full=1 on the next cycle.
  - Example: a read at cnt=1 gives empty=1 on the next cycle.
- dout = mem[rptr], combinational (first-word-fall-through).
  - Valid whenever empty=0.
  - Don't-care when empty=1.
  - Write-to-dout latency is 1 cycle from the accepting edge.
- Memory write occurs only on wr_acc.

Optional Feature:
- Macro: SYNC_FIFO_STICKY_ERR_EN.
- Defined:
  - overflow sets on any cycle with write && !wr_acc.
  - underflow sets on any cycle with read && !rd_acc.
  - Both hold until err_clr=1 at a clk edge.
  - If set and err_clr occur in the same cycle, set wins.
  - Both flags are cleared by rst.
- Not defined:
  - overflow and underflow are tied to 0.
  - err_clr is ignored.
  - No error logic is synthesised.

Test Plan:
- Reset then idle -> cnt=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Write 16 words 0x00..0x0F (defaults) -> after 14th write almost_full=1; after 16th full=1, cnt=16. A 17th write-only leaves cnt=16 and wptr unchanged, and sets overflow=1 if the macro is enabled.
- Full, then read+write with din=0xAA -> cnt stays 16, full stays 1. Draining returns 0x01..0x0F then 0xAA in order.
- Empty, then read only -> cnt=0, rptr unchanged, empty=1, underflow=1 if enabled. Then err_clr=1 -> underflow=0 next cycle.
- Empty, then read+write din=0x5C -> cnt=1, empty=0, dout=0x5C next cycle.
- Write 20 words and read 20 words interleaved to force pointer wrap, with rst asserted mid-stream -> order is preserved before the reset. After the reset: cnt=0, empty=1, and a write that was asserted during the rst cycle is not stored.
